// File: rtl/write_back_pkg.sv
// write_back shared types: register file, flag positions, stage states.
// Optional forwarding port is enabled by defining WRITE_BACK_FEEDBACK_EN.
package write_back_pkg;

  localparam int NREGS = 32;
  localparam int DW    = 32;

  typedef logic [$clog2(NREGS)-1:0] regind_t;
  typedef logic [DW-1:0]            regval_t;
  typedef regval_t [NREGS-1:0]      regfile_t;

  localparam regind_t FLAGS_IDX = regind_t'(31);

  localparam int FLAG_C = 30;
  localparam int FLAG_N = 29;
  localparam int FLAG_V = 28;
  localparam int FLAG_Z = 27;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPPER,
    ST_STORE
  } state_e;

endpackage

// File: rtl/write_back_store_port.sv
// Store port: latches address/data on start and holds the request
// until the memory drops waitrequest.
module store_port
  import write_back_pkg::*;
(
  input  logic    clock,
  input  logic    reset_n,
  input  logic    start_i,
  input  regval_t base_i,
  input  regval_t offset_i,
  input  regval_t data_i,
  input  logic    waitrequest_i,
  output regval_t address_o,
  output regval_t writedata_o,
  output logic    write_o,
  output logic    busy_o
);

  state_e  state_q, state_d;
  regval_t addr_q, data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_i && state_q == ST_IDLE) begin
        addr_q <= base_i + offset_i;
        data_q <= data_i;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_STORE;
      ST_STORE: if (!waitrequest_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    write_o     = (state_q == ST_STORE);
    busy_o      = (state_q == ST_STORE);
    address_o   = addr_q;
    writedata_o = data_q;
  end

endmodule

// File: rtl/write_back.sv
// Write-back stage: commits register/flag results, upper halves, and stores.
// Define WRITE_BACK_FEEDBACK_EN to forward the value being written.
module write_back
  import write_back_pkg::*;
#(
  parameter int REGISTER_COUNT = NREGS,
  parameter int DATA_WIDTH     = DW
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_is_valid,
  output logic                  in_hold,
  input  logic [31:0]           in_pc,
  input  regind_t               in_destination_register,
  input  logic                  in_is_writing_memory,
  input  logic [3:0]            in_flags,
  input  regval_t               in_destination_value,
  input  logic                  in_has_upper_value,
  input  regval_t               in_upper_value,
  input  regval_t               in_adjustment_value,
  input  logic                  in_has_flushed,
  output regfile_t              registers,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  output logic                  mem_write,
  input  logic                  mem_waitrequest,
  output regind_t               feedback_index,
  output regval_t               feedback_value,
  output logic                  feedback_is_valid
);

  localparam int unsigned RC = REGISTER_COUNT;

  state_e   state_q, state_d, cur;
  regfile_t regs_q, regs_d;
  regind_t  up_idx_q;
  regval_t  up_val_q;
  logic     store_busy;
  logic     accept, live, reg_beat, st_beat;
  regind_t  up_idx;
  logic     unused_pc;

  assign unused_pc = ^in_pc;

  assign cur      = store_busy ? ST_STORE : state_q;
  assign accept   = in_is_valid && (cur == ST_IDLE);
  assign live     = accept && !in_has_flushed;
  assign reg_beat = live && !in_is_writing_memory;
  assign st_beat  = live && in_is_writing_memory;
  assign up_idx   = regind_t'((32'(in_destination_register) + 32'd1) % RC);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      regs_q   <= '0;
      up_idx_q <= '0;
      up_val_q <= '0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      if (reg_beat && in_has_upper_value) begin
        up_idx_q <= up_idx;
        up_val_q <= in_upper_value;
      end
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (reg_beat && in_has_upper_value) state_d = ST_UPPER;
  end

  always_comb begin
    in_hold = (cur != ST_IDLE);
  end

  // Flags first so that a full write to the flags register wins.
  always_comb begin
    regs_d = regs_q;
    if (reg_beat) begin
      regs_d[FLAGS_IDX][FLAG_C:FLAG_Z] = in_flags;
      if (in_destination_register != '0)
        regs_d[in_destination_register] = in_destination_value;
    end
    if (cur == ST_UPPER && up_idx_q != '0)
      regs_d[up_idx_q] = up_val_q;
    regs_d[0] = '0;
  end

  assign registers = regs_q;

  store_port u_store (
    .clock         (clock),
    .reset_n       (reset_n),
    .start_i       (st_beat),
    .base_i        (regs_q[in_destination_register]),
    .offset_i      (in_adjustment_value),
    .data_i        (in_destination_value),
    .waitrequest_i (mem_waitrequest),
    .address_o     (mem_address),
    .writedata_o   (mem_writedata),
    .write_o       (mem_write),
    .busy_o        (store_busy)
  );

`ifdef WRITE_BACK_FEEDBACK_EN
  always_comb begin
    feedback_index    = '0;
    feedback_value    = '0;
    feedback_is_valid = 1'b0;
    unique case (1'b1)
      (cur == ST_UPPER): begin
        feedback_index    = up_idx_q;
        feedback_value    = up_val_q;
        feedback_is_valid = (up_idx_q != '0);
      end
      (cur == ST_IDLE): begin
        feedback_index    = in_destination_register;
        feedback_value    = in_destination_value;
        feedback_is_valid = in_is_valid && !in_is_writing_memory
                            && !in_has_flushed
                            && (in_destination_register != '0);
      end
      default: ;
    endcase
  end
`else
  assign feedback_index    = '0;
  assign feedback_value    = '0;
  assign feedback_is_valid = 1'b0;
`endif

endmodule

// File: tb/tb_write_back.sv
// Directed bench for write_back: register, upper, store, flush,
// register-0 and reset-abort scenarios.
module tb_write_back;
  import write_back_pkg::*;

  logic     clock = 0;
  logic     reset_n = 0;
  logic     in_is_valid = 0;
  logic     in_hold;
  logic [31:0] in_pc = 0;
  regind_t  in_destination_register = 0;
  logic     in_is_writing_memory = 0;
  logic [3:0] in_flags = 0;
  regval_t  in_destination_value = 0;
  logic     in_has_upper_value = 0;
  regval_t  in_upper_value = 0;
  regval_t  in_adjustment_value = 0;
  logic     in_has_flushed = 0;
  regfile_t registers;
  logic [31:0] mem_address, mem_writedata;
  logic     mem_write;
  logic     mem_waitrequest = 0;
  regind_t  feedback_index;
  regval_t  feedback_value;
  logic     feedback_is_valid;

  int checks = 0;
  int errors = 0;

`ifdef WRITE_BACK_FEEDBACK_EN
  localparam logic FB_ON = 1'b1;
`else
  localparam logic FB_ON = 1'b0;
`endif

  always #5 clock = ~clock;

  write_back dut (
    .clock(clock), .reset_n(reset_n),
    .in_is_valid(in_is_valid), .in_hold(in_hold), .in_pc(in_pc),
    .in_destination_register(in_destination_register),
    .in_is_writing_memory(in_is_writing_memory),
    .in_flags(in_flags),
    .in_destination_value(in_destination_value),
    .in_has_upper_value(in_has_upper_value),
    .in_upper_value(in_upper_value),
    .in_adjustment_value(in_adjustment_value),
    .in_has_flushed(in_has_flushed),
    .registers(registers),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_waitrequest(mem_waitrequest),
    .feedback_index(feedback_index), .feedback_value(feedback_value),
    .feedback_is_valid(feedback_is_valid)
  );

  task automatic drive(input regind_t d, input logic [31:0] v,
                       input logic [3:0] f, input logic st,
                       input logic up, input logic [31:0] uv,
                       input logic [31:0] adj, input logic fl);
    in_destination_register = d;
    in_destination_value    = v;
    in_flags                = f;
    in_is_writing_memory    = st;
    in_has_upper_value      = up;
    in_upper_value          = uv;
    in_adjustment_value     = adj;
    in_has_flushed          = fl;
    in_pc                   = in_pc + 4;
    in_is_valid             = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (registers !== '0) begin
      errors++; $display("FAIL reset_regs got nonzero want 0");
    end
    checks++;
    if ({mem_write, in_hold, feedback_is_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000",
               {mem_write, in_hold, feedback_is_valid});
    end
    checks++;
    if ({mem_address, mem_writedata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mem got %h/%h want 0/0", mem_address, mem_writedata);
    end
    reset_n = 1;
    @(posedge clock); #1;
  endtask

  task automatic test_register();
    drive(5'd5, 32'h12345678, 4'b1001, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (feedback_is_valid !== FB_ON) begin
      errors++;
      $display("FAIL reg_fb got %b want %b", feedback_is_valid, FB_ON);
    end
    @(posedge clock); #1;
    in_is_valid = 0;
    checks++;
    if (registers[5] !== 32'h12345678) begin
      errors++; $display("FAIL reg_r5 got %h want 12345678", registers[5]);
    end
    checks++;
    if (registers[FLAGS_IDX] !== 32'h48000000) begin
      errors++;
      $display("FAIL reg_flags got %h want 48000000", registers[FLAGS_IDX]);
    end
    checks++;
    if (in_hold !== 1'b0) begin
      errors++; $display("FAIL reg_hold got %b want 0", in_hold);
    end
  endtask

  task automatic test_multiply();
    drive(5'd6, 32'hFFFF0000, 4'b0100, 0, 1, 32'h1, 0, 0);
    @(posedge clock); #1;
    in_is_valid = 0;
    checks++;
    if (registers[6] !== 32'hFFFF0000 || registers[7] !== 32'h0) begin
      errors++;
      $display("FAIL mul_edge1 got r6=%h r7=%h want ffff0000/0",
               registers[6], registers[7]);
    end
    checks++;
    if (in_hold !== 1'b1) begin
      errors++; $display("FAIL mul_hold1 got %b want 1", in_hold);
    end
    @(posedge clock); #1;
    checks++;
    if (registers[7] !== 32'h1) begin
      errors++; $display("FAIL mul_r7 got %h want 1", registers[7]);
    end
    checks++;
    if (in_hold !== 1'b0) begin
      errors++; $display("FAIL mul_hold2 got %b want 0", in_hold);
    end
    checks++;
    if (registers[FLAGS_IDX] !== 32'h20000000) begin
      errors++;
      $display("FAIL mul_flags got %h want 20000000", registers[FLAGS_IDX]);
    end
  endtask

  task automatic test_store();
    int hi = 0;
    int hold_hi = 0;
    drive(5'd3, 32'h1000, 4'b0000, 0, 0, 0, 0, 0);
    @(posedge clock); #1;
    drive(5'd3, 32'hCAFEBABE, 4'b1111, 1, 0, 0, 32'h10, 0);
    mem_waitrequest = 1;
    @(posedge clock); #1;
    in_is_valid = 0;
    for (int c = 0; c < 10; c++) begin
      if (mem_write) begin
        hi++;
        checks++;
        if (mem_address !== 32'h1010 || mem_writedata !== 32'hCAFEBABE) begin
          errors++;
          $display("FAIL st_latch got %h/%h want 00001010/cafebabe",
                   mem_address, mem_writedata);
        end
      end
      if (in_hold) hold_hi++;
      if (hi >= 4) mem_waitrequest = 0;
      @(posedge clock); #1;
    end
    mem_waitrequest = 0;
    checks++;
    if (hi != 4) begin
      errors++; $display("FAIL st_write_cycles got %0d want 4", hi);
    end
    checks++;
    if (hold_hi != 4) begin
      errors++; $display("FAIL st_hold_cycles got %0d want 4", hold_hi);
    end
    checks++;
    if (registers[3] !== 32'h1000 || registers[FLAGS_IDX] !== 32'h0) begin
      errors++;
      $display("FAIL st_nochange got r3=%h fl=%h want 1000/0",
               registers[3], registers[FLAGS_IDX]);
    end
  endtask

  task automatic test_flush();
    drive(5'd8, 32'hDEAD, 4'b1111, 0, 1, 32'h55, 0, 1);
    @(posedge clock); #1;
    in_is_valid = 0;
    checks++;
    if (registers[8] !== 32'h0 || registers[FLAGS_IDX] !== 32'h0) begin
      errors++;
      $display("FAIL fl_regs got r8=%h fl=%h want 0/0",
               registers[8], registers[FLAGS_IDX]);
    end
    checks++;
    if ({mem_write, in_hold} !== 2'b00) begin
      errors++;
      $display("FAIL fl_ctl got %b want 00", {mem_write, in_hold});
    end
  endtask

  task automatic test_zero_wrap();
    drive(5'd0, 32'hFFFFFFFF, 4'b0110, 0, 0, 0, 0, 0);
    #1;
    checks++;
    if (feedback_is_valid !== 1'b0) begin
      errors++; $display("FAIL r0_fb got %b want 0", feedback_is_valid);
    end
    @(posedge clock); #1;
    checks++;
    if (registers[0] !== 32'h0 || registers[FLAGS_IDX] !== 32'h30000000) begin
      errors++;
      $display("FAIL r0_write got r0=%h fl=%h want 0/30000000",
               registers[0], registers[FLAGS_IDX]);
    end
    drive(5'd31, 32'hA5A5A5A5, 4'b1111, 0, 1, 32'h77, 0, 0);
    @(posedge clock); #1;
    in_is_valid = 0;
    checks++;
    if (registers[31] !== 32'hA5A5A5A5 || in_hold !== 1'b1) begin
      errors++;
      $display("FAIL wrap_lower got r31=%h hold=%b want a5a5a5a5/1",
               registers[31], in_hold);
    end
    checks++;
    if (feedback_is_valid !== 1'b0) begin
      errors++; $display("FAIL wrap_fb got %b want 0", feedback_is_valid);
    end
    @(posedge clock); #1;
    checks++;
    if (registers[0] !== 32'h0 || in_hold !== 1'b0) begin
      errors++;
      $display("FAIL wrap_r0 got r0=%h hold=%b want 0/0",
               registers[0], in_hold);
    end
  endtask

  task automatic test_reset_store();
    drive(5'd5, 32'h1, 4'b0000, 1, 0, 0, 32'h4, 0);
    mem_waitrequest = 1;
    @(posedge clock); #1;
    in_is_valid = 0;
    checks++;
    if (mem_write !== 1'b1 || mem_address !== 32'h1234567C) begin
      errors++;
      $display("FAIL rs_pre got wr=%b addr=%h want 1/1234567c",
               mem_write, mem_address);
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if ({mem_write, in_hold} !== 2'b00) begin
      errors++;
      $display("FAIL rs_abort got %b want 00", {mem_write, in_hold});
    end
    @(posedge clock); #1;
    reset_n = 1;
    mem_waitrequest = 0;
    @(posedge clock); #1;
    checks++;
    if ({mem_write, in_hold} !== 2'b00 || registers !== '0) begin
      errors++;
      $display("FAIL rs_after got ctl=%b r5=%h want 00/0",
               {mem_write, in_hold}, registers[5]);
    end
  endtask

  initial begin
    test_reset();
    test_register();
    test_multiply();
    test_store();
    test_flush();
    test_zero_wrap();
    test_reset_store();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
